// File: rtl/ram_rd_pkg.sv
// ram_rd_pkg
// Shared types and constants for the RAM stream reader.
//   DefAddrW  : default RAM address width
//   DefDataW  : default RAM data width
//   FifoDepth : entries of buffering between the RAM read port and the stream
//   state_e   : reader FSM states
package ram_rd_pkg;

    localparam int unsigned DefAddrW  = 11;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned FifoDepth = 2;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } state_e;

endpackage

// File: rtl/ram_rd_skid.sv
// ram_rd_skid
// Two-entry FIFO holding {last, data} words between the RAM read port and the
// output stream. Push and pop may occur in the same cycle. The head entry is
// presented combinationally on o_rdata whenever o_valid is high.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_wdata: write strobe and word
//   i_pop          : remove the head entry (ignored when empty)
//   o_rdata        : head entry
//   o_valid        : FIFO non-empty
//   o_count        : current occupancy (0..2)
module ram_rd_skid #(
    parameter int unsigned WIDTH = 9
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_valid,
    output logic [1:0]       o_count
);

    logic [WIDTH-1:0] r_mem [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_count;

    logic             w_push;
    logic             w_pop;

    assign w_pop  = i_pop & (r_count != 2'd0);
    // A push into a full FIFO is only accepted when the head leaves the same cycle.
    assign w_push = i_push & ((r_count != 2'd2) | w_pop);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= i_wdata;
                r_wptr        <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_valid = (r_count != 2'd0);
    assign o_count = r_count;

endmodule

// File: rtl/ram_stream_reader.sv
// ram_stream_reader
// Walks a contiguous RAM address window on a Start command and converts the
// one-cycle-latency synchronous RAM reads into a valid/ready byte stream with
// full backpressure. At most FifoDepth bytes are buffered or in flight.
// Ports:
//   RClk, Rst_n            : clock (shared with RAM read port), async active-low reset
//   Start, StartAddr, Len  : command, sampled only in idle
//   Busy, Done             : command in progress / one-cycle completion pulse
//   RA, RClk_En, RD        : RAM read address (registered), enable, read data
//   Out_Data, Out_Valid,
//   Out_Ready, Out_Last    : output byte stream
module ram_stream_reader #(
    parameter int unsigned ADDR_W = ram_rd_pkg::DefAddrW,
    parameter int unsigned DATA_W = ram_rd_pkg::DefDataW,
    parameter int unsigned LEN_W  = ADDR_W + 1
) (
    input  logic              RClk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] StartAddr,
    input  logic [LEN_W-1:0]  Len,
    output logic              Busy,
    output logic              Done,
    output logic [ADDR_W-1:0] RA,
    output logic              RClk_En,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] Out_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic              Out_Last
);

    import ram_rd_pkg::*;

    state_e            r_state;
    state_e            w_state_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic              r_inflight;
    logic              r_inflight_last;

    logic              w_issue;
    logic              w_pop;
    logic              w_start_ok;
    logic [2:0]        w_load;
    logic [DATA_W:0]   w_head;
    logic              w_fifo_valid;
    logic [1:0]        w_fifo_count;

    assign w_start_ok = (r_state == StIdle) & Start;
    assign w_pop      = w_fifo_valid & Out_Ready;

    // Bytes that will still occupy buffering after this cycle's pop; a read may
    // issue only if its byte is guaranteed a slot when it returns.
    assign w_load  = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue = (r_state == StRun) && (r_rem != '0) && (w_load < 3'(FifoDepth));

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge RClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (Start) begin
                    w_state_next = (Len == '0) ? StFin : StRun;
                end
            end
            StRun: begin
                if (w_issue && (r_rem == LEN_W'(1))) begin
                    w_state_next = StDrain;
                end
            end
            StDrain: begin
                // Last beat leaving with nothing behind it in the pipe.
                if (!r_inflight && w_pop && (w_fifo_count == 2'd1) && w_head[DATA_W]) begin
                    w_state_next = StFin;
                end
            end
            StFin: begin
                w_state_next = StIdle;
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Address / remaining counters and in-flight tracking
    // ---------------------------------------------------------------------
    always_ff @(posedge RClk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_addr          <= '0;
            r_rem           <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_addr <= StartAddr;
                r_rem  <= Len;
            end else if (w_issue) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_rem == LEN_W'(1));
        end
    end

    // ---------------------------------------------------------------------
    // Return buffer: RD is captured unconditionally the cycle after an issue
    // ---------------------------------------------------------------------
    ram_rd_skid #(
        .WIDTH (DATA_W + 1)
    ) u_skid (
        .i_clk   (RClk),
        .i_rst_n (Rst_n),
        .i_push  (r_inflight),
        .i_wdata ({r_inflight_last, RD}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_valid (w_fifo_valid),
        .o_count (w_fifo_count)
    );

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign RA        = r_addr;
    assign RClk_En   = w_issue;
    assign Busy      = (r_state != StIdle);
    assign Done      = (r_state == StFin);
    assign Out_Valid = w_fifo_valid;
    assign Out_Data  = w_head[DATA_W-1:0];
    assign Out_Last  = w_fifo_valid & w_head[DATA_W];

endmodule
